md5_match_collector: RTL and testbench



---
 rtl/md5_pkg.sv | 36 +++
 rtl/md5_match_pick.sv | 27 ++
 rtl/md5_match_collector.sv | 180 ++++++++++++++++++
 tb/tb_md5_match_collector.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/md5_pkg.sv
// Shared types and helpers for the MD5 match collector and its lane picker.
package md5_pkg;

    localparam int DIGEST_W      = 128;
    localparam int MSG_W_DEFAULT = 152;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        FLUSH,
        DONE
    } state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Lane vectors are at most 16 wide; narrower callers zero-extend.
    function automatic int popcount(input logic [15:0] bits);
        int total;
        total = 0;
        for (int i = 0; i < 16; i++) begin
            if (bits[i]) begin
                total++;
            end
        end
        return total;
    endfunction

endpackage

// File: rtl/md5_match_pick.sv
// Lowest-index priority select of the hit lane and its message.
module md5_match_pick #(
    parameter int NUM_CORES = 4,
    parameter int MSG_WIDTH = 152,
    parameter int LANE_W    = 2
) (
    input  logic [NUM_CORES-1:0]           hits_i,
    input  logic [MSG_WIDTH*NUM_CORES-1:0] msgs_i,
    output logic                           any_o,
    output logic [LANE_W-1:0]              lane_o,
    output logic [MSG_WIDTH-1:0]           msg_o
);

    // Scanning downwards lets the lowest hit lane overwrite the others.
    always_comb begin
        any_o  = |hits_i;
        lane_o = '0;
        msg_o  = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (hits_i[i]) begin
                lane_o = LANE_W'(i);
                msg_o  = msgs_i[MSG_WIDTH*i +: MSG_WIDTH];
            end
        end
    end

endmodule

// File: rtl/md5_match_collector.sv
// Multi-lane digest collector: tracks messages in flight, compares returned digests
// against the job target and reports the first match, its lane and a match count.
module md5_match_collector
    import md5_pkg::*;
#(
    parameter int NUM_CORES     = 4,
    parameter int MSG_WIDTH     = MSG_W_DEFAULT,
    parameter int MAX_INFLIGHT  = 255,
    parameter int STOP_ON_MATCH = 0,
    parameter int LANE_W        = (NUM_CORES > 1) ? clog2(NUM_CORES) : 1,
    parameter int CNT_W         = clog2(MAX_INFLIGHT + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start_i,
    input  logic [DIGEST_W-1:0]            target_hash_i,
    input  logic                           last_i,
    input  logic [NUM_CORES-1:0]           launch_valid_i,
    input  logic [NUM_CORES-1:0]           res_valid_i,
    input  logic [DIGEST_W*NUM_CORES-1:0]  res_hash_i,
    input  logic [MSG_WIDTH*NUM_CORES-1:0] res_msg_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           match_o,
    output logic [LANE_W-1:0]              match_lane_o,
    output logic [MSG_WIDTH-1:0]           match_msg_o,
    output logic [CNT_W-1:0]               match_count_o,
    output logic                           inflight_err_o
);

    localparam int MCOUNT_MAX = (1 << CNT_W) - 1;

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               count_q, count_d;
    logic [DIGEST_W-1:0]            target_q, target_d;
    logic [NUM_CORES-1:0]           s1Hit_q, s1Hit_d;
    logic [MSG_WIDTH*NUM_CORES-1:0] s1Msg_q, s1Msg_d;
    logic                           done_q, done_d;
    logic                           match_q, match_d;
    logic [LANE_W-1:0]              lane_q, lane_d;
    logic [MSG_WIDTH-1:0]           msg_q, msg_d;
    logic [CNT_W-1:0]               mcount_q, mcount_d;
    logic                           err_q, err_d;

    logic [NUM_CORES-1:0] laneHits;
    logic                 pickAny;
    logic [LANE_W-1:0]    pickLane;
    logic [MSG_WIDTH-1:0] pickMsg;
    logic                 startOk, active, firstHit, drained, s1Load, countErr, lateLaunch;
    int                   launchCnt, resCnt, nextCount, nextMatches;

    always_comb begin
        laneHits = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            laneHits[i] = res_valid_i[i] && (res_hash_i[DIGEST_W*i +: DIGEST_W] == target_q);
        end
    end

    md5_match_pick #(
        .NUM_CORES (NUM_CORES),
        .MSG_WIDTH (MSG_WIDTH),
        .LANE_W    (LANE_W)
    ) u_pick (
        .hits_i (s1Hit_q),
        .msgs_i (s1Msg_q),
        .any_o  (pickAny),
        .lane_o (pickLane),
        .msg_o  (pickMsg)
    );

    always_comb begin
        startOk    = start_i && (state_q == IDLE || state_q == DONE);
        active     = state_q inside {RUN, DRAIN, FLUSH};
        launchCnt  = (startOk || active) ? popcount(16'(launch_valid_i)) : 0;
        resCnt     = active ? popcount(16'(res_valid_i)) : 0;
        firstHit   = pickAny && !match_q && (state_q == RUN || state_q == DRAIN);
        drained    = (count_q == '0) && !(|res_valid_i) && !(|launch_valid_i);
        lateLaunch = (state_q == DRAIN || state_q == FLUSH) && (|launch_valid_i);

        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (startOk) state_d = RUN;
            RUN: begin
                if (STOP_ON_MATCH != 0 && firstHit) state_d = FLUSH;
                else if (last_i)                    state_d = DRAIN;
            end
            DRAIN: begin
                if (STOP_ON_MATCH != 0 && firstHit) state_d = FLUSH;
                else if (drained)                   state_d = DONE;
            end
            FLUSH:   if (drained) state_d = DONE;
            default: state_d = IDLE;
        endcase

        // Launches and returns in the same cycle net out before clamping.
        nextCount = int'(count_q) + launchCnt - resCnt;
        countErr  = 1'b0;
        if (nextCount < 0) begin
            count_d  = '0;
            countErr = 1'b1;
        end else if (nextCount > MAX_INFLIGHT) begin
            count_d  = CNT_W'(MAX_INFLIGHT);
            countErr = 1'b1;
        end else begin
            count_d = CNT_W'(nextCount);
        end

        // Only results that will still be compared next cycle enter stage 1.
        s1Load  = (state_q == RUN || state_q == DRAIN) && (state_d == RUN || state_d == DRAIN);
        s1Hit_d = s1Load ? laneHits : '0;
        s1Msg_d = s1Load ? res_msg_i : s1Msg_q;

        target_d    = target_q;
        done_d      = done_q;
        match_d     = match_q;
        lane_d      = lane_q;
        msg_d       = msg_q;
        mcount_d    = mcount_q;
        err_d       = err_q;
        nextMatches = int'(mcount_q) + popcount(16'(s1Hit_q));

        if (startOk) begin
            target_d = target_hash_i;
            done_d   = 1'b0;
            match_d  = 1'b0;
            lane_d   = '0;
            msg_d    = '0;
            mcount_d = '0;
            err_d    = 1'b0;
        end else if (pickAny && (state_q == RUN || state_q == DRAIN)) begin
            if (!match_q) begin
                match_d = 1'b1;
                lane_d  = pickLane;
                msg_d   = pickMsg;
            end
            mcount_d = (nextMatches > MCOUNT_MAX) ? CNT_W'(MCOUNT_MAX) : CNT_W'(nextMatches);
        end

        if (state_d == DONE && state_q != DONE) done_d = 1'b1;
        if (STOP_ON_MATCH != 0 && firstHit)     done_d = 1'b1;
        if (countErr || lateLaunch)             err_d  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            target_q <= '0;
            s1Hit_q  <= '0;
            s1Msg_q  <= '0;
            done_q   <= 1'b0;
            match_q  <= 1'b0;
            lane_q   <= '0;
            msg_q    <= '0;
            mcount_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            target_q <= target_d;
            s1Hit_q  <= s1Hit_d;
            s1Msg_q  <= s1Msg_d;
            done_q   <= done_d;
            match_q  <= match_d;
            lane_q   <= lane_d;
            msg_q    <= msg_d;
            mcount_q <= mcount_d;
            err_q    <= err_d;
        end
    end

    assign busy_o         = state_q inside {RUN, DRAIN, FLUSH};
    assign done_o         = done_q;
    assign match_o        = match_q;
    assign match_lane_o   = lane_q;
    assign match_msg_o    = msg_q;
    assign match_count_o  = mcount_q;
    assign inflight_err_o = err_q;

endmodule

// File: tb/tb_md5_match_collector.sv
// Directed bench for md5_match_collector: a per-cycle vector table for whole jobs,
// plus hand sequences for count netting, underflow, reset mid-drain and stop-on-match.
module tb_md5_match_collector;

    localparam logic [127:0] TARGET = 128'h0123456789abcdeffedcba9876543210;

    logic         clk, reset, start, last;
    logic [127:0] targetHash;
    logic [3:0]   launchValid, resValid;
    logic [511:0] resHash;
    logic [607:0] resMsg;

    logic         busy0, done0, match0, err0;
    logic [1:0]   lane0;
    logic [151:0] msg0;
    logic [7:0]   count0;
    logic         busy1, done1, match1, err1;
    logic [1:0]   lane1;
    logic [151:0] msg1;
    logic [7:0]   count1;

    int checks = 0;
    int errors = 0;

    md5_match_collector #(.NUM_CORES(4), .MSG_WIDTH(152), .MAX_INFLIGHT(255), .STOP_ON_MATCH(0)) dut0 (
        .clk(clk), .reset(reset), .start_i(start), .target_hash_i(targetHash), .last_i(last),
        .launch_valid_i(launchValid), .res_valid_i(resValid), .res_hash_i(resHash), .res_msg_i(resMsg),
        .busy_o(busy0), .done_o(done0), .match_o(match0), .match_lane_o(lane0),
        .match_msg_o(msg0), .match_count_o(count0), .inflight_err_o(err0)
    );

    md5_match_collector #(.NUM_CORES(4), .MSG_WIDTH(152), .MAX_INFLIGHT(255), .STOP_ON_MATCH(1)) dut1 (
        .clk(clk), .reset(reset), .start_i(start), .target_hash_i(targetHash), .last_i(last),
        .launch_valid_i(launchValid), .res_valid_i(resValid), .res_hash_i(resHash), .res_msg_i(resMsg),
        .busy_o(busy1), .done_o(done1), .match_o(match1), .match_lane_o(lane1),
        .match_msg_o(msg1), .match_count_o(count1), .inflight_err_o(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        last;
        logic [3:0]  launch;
        logic [3:0]  res;
        logic [3:0]  hit;
        logic [63:0] msgs;
        logic        expBusy;
        logic        expDone;
        logic        expMatch;
        logic [1:0]  expLane;
        logic [15:0] expMsg;
        logic [7:0]  expCount;
    } vec_t;

    vec_t vecs[16];

    task automatic checkOutput(input string name, input logic [151:0] actual, input logic [151:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of stimulus, then return #1 after the edge with inputs idle.
    task automatic applyStimulus(input logic s, input logic l, input logic [3:0] launch,
                                 input logic [3:0] res, input logic [3:0] hit, input logic [63:0] msgs);
        start       = s;
        last        = l;
        launchValid = launch;
        resValid    = res;
        for (int i = 0; i < 4; i++) begin
            resHash[128*i +: 128] = hit[i] ? TARGET : ~TARGET;
            resMsg[152*i +: 152]  = 152'(msgs[16*i +: 16]);
        end
        @(posedge clk);
        #1;
        start       = 1'b0;
        last        = 1'b0;
        launchValid = '0;
        resValid    = '0;
    endtask

    task automatic resetDut();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        last        = 1'b0;
        targetHash  = TARGET;
        launchValid = '0;
        resValid    = '0;
        resHash     = '0;
        resMsg      = '0;

        // Job A: no hits, last with final returns; Job B: lane 2 hit; Job C: lanes 1+3 then lane 0.
        vecs[0]  = '{1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 64'h0,                   1'b1, 1'b0, 1'b0, 2'd0, 16'h0,   8'd0};
        vecs[1]  = '{1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 64'h0,                   1'b1, 1'b0, 1'b0, 2'd0, 16'h0,   8'd0};
        vecs[2]  = '{1'b0, 1'b0, 4'h0, 4'hF, 4'h0, 64'h0,                   1'b1, 1'b0, 1'b0, 2'd0, 16'h0,   8'd0};
        vecs[3]  = '{1'b0, 1'b1, 4'h0, 4'hF, 4'h0, 64'h0,                   1'b1, 1'b0, 1'b0, 2'd0, 16'h0,   8'd0};
        vecs[4]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 64'h0,                   1'b0, 1'b1, 1'b0, 2'd0, 16'h0,   8'd0};
        vecs[5]  = '{1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 64'h0,                   1'b1, 1'b0, 1'b0, 2'd0, 16'h0,   8'd0};
        vecs[6]  = '{1'b0, 1'b0, 4'h0, 4'h4, 4'h4, 64'h0000_0ABC_0000_0000, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0,   8'd0};
        vecs[7]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 64'h0,                   1'b1, 1'b0, 1'b1, 2'd2, 16'hABC, 8'd1};
        vecs[8]  = '{1'b0, 1'b1, 4'h0, 4'hB, 4'h0, 64'h0,                   1'b1, 1'b0, 1'b1, 2'd2, 16'hABC, 8'd1};
        vecs[9]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 64'h0,                   1'b0, 1'b1, 1'b1, 2'd2, 16'hABC, 8'd1};
        vecs[10] = '{1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 64'h0,                   1'b1, 1'b0, 1'b0, 2'd0, 16'h0,   8'd0};
        vecs[11] = '{1'b0, 1'b0, 4'h0, 4'hA, 4'hA, 64'h0333_0000_0111_0000, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0,   8'd0};
        vecs[12] = '{1'b0, 1'b0, 4'h0, 4'h1, 4'h1, 64'h0000_0000_0000_00AA, 1'b1, 1'b0, 1'b1, 2'd1, 16'h111, 8'd2};
        vecs[13] = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 64'h0,                   1'b1, 1'b0, 1'b1, 2'd1, 16'h111, 8'd3};
        vecs[14] = '{1'b0, 1'b1, 4'h0, 4'h4, 4'h0, 64'h0,                   1'b1, 1'b0, 1'b1, 2'd1, 16'h111, 8'd3};
        vecs[15] = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 64'h0,                   1'b0, 1'b1, 1'b1, 2'd1, 16'h111, 8'd3};

        resetDut();
        checkOutput("reset busy", busy0, 1'b0);
        checkOutput("reset done", done0, 1'b0);
        checkOutput("reset match", match0, 1'b0);
        checkOutput("reset count", count0, 8'd0);
        checkOutput("reset err", err0, 1'b0);

        for (int r = 0; r < 16; r++) begin
            applyStimulus(vecs[r].start, vecs[r].last, vecs[r].launch, vecs[r].res, vecs[r].hit, vecs[r].msgs);
            checkOutput($sformatf("row%0d busy", r), busy0, vecs[r].expBusy);
            checkOutput($sformatf("row%0d done", r), done0, vecs[r].expDone);
            checkOutput($sformatf("row%0d match", r), match0, vecs[r].expMatch);
            checkOutput($sformatf("row%0d lane", r), lane0, vecs[r].expLane);
            checkOutput($sformatf("row%0d msg", r), msg0, 152'(vecs[r].expMsg));
            checkOutput($sformatf("row%0d count", r), count0, vecs[r].expCount);
            checkOutput($sformatf("row%0d err", r), err0, 1'b0);
        end

        // Netting, underflow, ignored start and reset mid-drain.
        $display("[TB] inflight netting and reset sequence");
        resetDut();
        applyStimulus(1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 64'h0);
        applyStimulus(1'b0, 1'b0, 4'h1, 4'h0, 4'h0, 64'h0);
        applyStimulus(1'b0, 1'b0, 4'hF, 4'h3, 4'h1, 64'h0000_0000_0000_05A5);
        checkOutput("net count", dut0.count_q, 8'd7);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 64'h0);
        checkOutput("net match", match0, 1'b1);
        checkOutput("net lane", lane0, 2'd0);
        checkOutput("net msg", msg0, 152'h5A5);
        checkOutput("net match count", count0, 8'd1);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'hF, 4'h0, 64'h0);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h7, 4'h0, 64'h0);
        checkOutput("drained count", dut0.count_q, 8'd0);
        checkOutput("no err before underflow", err0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h1, 4'h0, 64'h0);
        checkOutput("underflow count", dut0.count_q, 8'd0);
        checkOutput("underflow err", err0, 1'b1);
        targetHash = ~TARGET;
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 64'h0);
        targetHash = TARGET;
        checkOutput("busy start busy", busy0, 1'b1);
        checkOutput("busy start err kept", err0, 1'b1);
        checkOutput("busy start match kept", match0, 1'b1);
        applyStimulus(1'b0, 1'b1, 4'h7, 4'h0, 4'h0, 64'h0);
        checkOutput("drain busy", busy0, 1'b1);
        checkOutput("drain count", dut0.count_q, 8'd3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid reset busy", busy0, 1'b0);
        checkOutput("mid reset done", done0, 1'b0);
        checkOutput("mid reset match", match0, 1'b0);
        checkOutput("mid reset lane", lane0, 2'd0);
        checkOutput("mid reset msg", msg0, 152'h0);
        checkOutput("mid reset match count", count0, 8'd0);
        checkOutput("mid reset err", err0, 1'b0);
        checkOutput("mid reset inflight", dut0.count_q, 8'd0);
        reset = 1'b0;

        // Stop-on-match: done with the first match, later hits discarded while flushing.
        $display("[TB] stop-on-match sequence");
        resetDut();
        applyStimulus(1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 64'h0);
        applyStimulus(1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 64'h0);
        applyStimulus(1'b0, 1'b0, 4'h3, 4'h0, 4'h0, 64'h0);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h1, 4'h1, 64'h0000_0000_0000_0777);
        checkOutput("stop done early", done1, 1'b0);
        checkOutput("stop match early", match1, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 64'h0);
        checkOutput("stop done", done1, 1'b1);
        checkOutput("stop busy", busy1, 1'b1);
        checkOutput("stop match", match1, 1'b1);
        checkOutput("stop lane", lane1, 2'd0);
        checkOutput("stop msg", msg1, 152'h777);
        checkOutput("stop match count", count1, 8'd1);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'hF, 4'h8, 64'h0999_0000_0000_0000);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'hF, 4'h0, 64'h0);
        checkOutput("flush match count", count1, 8'd1);
        checkOutput("flush lane", lane1, 2'd0);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h1, 4'h0, 64'h0);
        checkOutput("flush busy", busy1, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 64'h0);
        checkOutput("flush end busy", busy1, 1'b0);
        checkOutput("flush end done", done1, 1'b1);
        checkOutput("flush end err", err1, 1'b0);
        checkOutput("flush end count", count1, 8'd1);
        checkOutput("flush end inflight", dut1.count_q, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
